// File: rtl/memory_write_monitor.sv
// Registered write-access monitor: flags writes whose requester ID is not allowed at the target address.
// Optional saturating violation counter on viol_count_o, enabled by defining MWM_VIOL_COUNT_EN.
module memory_write_monitor #(
    parameter int         ADDR_W    = 4,
    parameter int         DATA_W    = 4,
    parameter int         ID_W      = 2,
    parameter logic [1:0] VIOL_CODE = 2'b11
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_i,
    input  logic [ADDR_W-1:0]                 write_addr_i,
    input  logic [DATA_W-1:0]                 write_data_i,
    input  logic [ID_W-1:0]                   write_id_i,
    output logic [2+DATA_W+ADDR_W+ID_W:0]     monitor_o,
    output logic                              write_ok_o
`ifdef MWM_VIOL_COUNT_EN
    ,
    output logic [7:0]                        viol_count_o
`endif
);

    localparam int MON_W = 3 + DATA_W + ADDR_W + ID_W;

    localparam logic [ID_W-1:0] ID_NONE = {ID_W{1'b0}};
    localparam logic [ID_W-1:0] ID_MID  = {{(ID_W-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0] ID_HIGH = {{(ID_W-2){1'b0}}, 2'b10};

    // The two address MSBs select the region: lower half open, then two owned quarters.
    function automatic logic policy_allows(input logic [ADDR_W-1:0] addr,
                                           input logic [ID_W-1:0]   id);
        logic allow_v;
        case (addr[ADDR_W-1 -: 2])
            2'b00, 2'b01: allow_v = (id != ID_NONE);
            2'b10:        allow_v = (id == ID_MID);
            2'b11:        allow_v = (id == ID_HIGH);
            default:      allow_v = 1'b0;
        endcase
        return allow_v;
    endfunction

    // Unknown inputs reduce to X under XOR; synthesis sees this as constant false.
    function automatic logic has_unknown(input logic [ADDR_W+DATA_W+ID_W-1:0] bus);
        return ((^bus) === 1'bx);
    endfunction

    logic               idle_s;
    logic               auth_s;
    logic               viol_s;
    logic [MON_W-1:0]   report_s;
    logic [MON_W-1:0]   monitor_r;
    logic               write_ok_r;

    // Classify the currently presented write.
    always_comb begin
        idle_s   = 1'b1;
        auth_s   = 1'b0;
        viol_s   = 1'b0;
        report_s = {MON_W{1'b0}};
        if (has_unknown({write_addr_i, write_data_i, write_id_i}) || (write_id_i == ID_NONE)) begin
            idle_s = 1'b1;
        end else begin
            idle_s = 1'b0;
            auth_s = policy_allows(write_addr_i, write_id_i);
            viol_s = ~auth_s;
        end
        if (viol_s) begin
            report_s = {VIOL_CODE, write_data_i, write_addr_i, write_id_i, 1'b1};
        end else begin
            report_s = {MON_W{1'b0}};
        end
    end

    // Output registers: one-cycle latency, each cycle reflects only the latest write.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            monitor_r  <= {MON_W{1'b0}};
            write_ok_r <= 1'b0;
        end else begin
            monitor_r  <= report_s;
            write_ok_r <= auth_s & ~idle_s;
        end
    end

    assign monitor_o  = monitor_r;
    assign write_ok_o = write_ok_r;

`ifdef MWM_VIOL_COUNT_EN
    logic [7:0] viol_count_r;

    // Saturating violation counter; reset wins over a coincident violation.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            viol_count_r <= 8'h00;
        end else if (viol_s && (viol_count_r != 8'hFF)) begin
            viol_count_r <= viol_count_r + 8'h01;
        end else begin
            viol_count_r <= viol_count_r;
        end
    end

    assign viol_count_o = viol_count_r;
`endif

endmodule

// File: tb/tb_memory_write_monitor.sv
// Randomized self-checking bench for memory_write_monitor against an address/ID policy model.
// Counter checks are compiled in only when MWM_VIOL_COUNT_EN is defined.
module tb_memory_write_monitor;

    logic        clk;
    logic        rst;
    logic [3:0]  addr;
    logic [3:0]  data;
    logic [1:0]  id;
    logic [12:0] monitor;
    logic        write_ok;
`ifdef MWM_VIOL_COUNT_EN
    logic [7:0]  viol_count;
`endif

    int vectors  = 0;
    int failures = 0;

    memory_write_monitor dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .write_addr_i (addr),
        .write_data_i (data),
        .write_id_i   (id),
        .monitor_o    (monitor),
        .write_ok_o   (write_ok)
`ifdef MWM_VIOL_COUNT_EN
        ,
        .viol_count_o (viol_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Policy model written directly from the address map.
    function automatic int model_authorized(input int a, input int i);
        if (i == 0) return 0;
        if (a < 8) return 1;
        if (a < 12) return (i == 1) ? 1 : 0;
        return (i == 2) ? 1 : 0;
    endfunction

    int exp_mon   = 0;
    int exp_ok    = 0;
    int exp_cnt   = 0;
    bit model_on  = 1'b0;

    // Model state advances on every rising edge, exactly as the outputs should.
    always @(posedge clk) begin
        int a, d, i, viol;
        a = int'(addr); d = int'(data); i = int'(id);
        viol = (i != 0 && model_authorized(a, i) == 0) ? 1 : 0;
        model_on <= 1'b1;
        if (rst) begin
            exp_mon <= 0;
            exp_ok  <= 0;
            exp_cnt <= 0;
        end else begin
            exp_ok  <= model_authorized(a, i);
            exp_mon <= viol ? ((3 * 2048) + (d * 128) + (a * 8) + (i * 2) + 1) : 0;
            if (viol && exp_cnt < 255) exp_cnt <= exp_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("model_monitor", int'(monitor), exp_mon);
            check("model_write_ok", int'(write_ok), exp_ok);
`ifdef MWM_VIOL_COUNT_EN
            check("model_viol_count", int'(viol_count), exp_cnt);
`endif
        end
    end

    task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] d, input logic [1:0] i);
        @(negedge clk);
        rst = r; addr = a; data = d; id = i;
    endtask

    // Apply one write and pin the result against a hand-computed value.
    task automatic lit(input string name, input logic [3:0] a, input logic [3:0] d,
                       input logic [1:0] i, input logic [12:0] em, input logic eo);
        drive(1'b0, a, d, i);
        @(posedge clk); #1;
        check({name, "_monitor"}, int'(monitor), int'(em));
        check({name, "_ok"}, int'(write_ok), int'(eo));
    endtask

    initial begin
        rst = 1'b1; addr = 4'h0; data = 4'h0; id = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_monitor", int'(monitor), 0);
        check("reset_ok", int'(write_ok), 0);
`ifdef MWM_VIOL_COUNT_EN
        check("reset_count", int'(viol_count), 0);
`endif

        lit("r031", 4'h9, 4'hF, 2'b10, 13'b11_1111_1001_10_1, 1'b0);
        lit("r032", 4'hA, 4'hA, 2'b01, 13'b0, 1'b1);
        lit("r033", 4'hA, 4'hF, 2'b11, 13'b11_1111_1010_11_1, 1'b0);
`ifdef MWM_VIOL_COUNT_EN
        check("r033_count", int'(viol_count), 2);
`endif
        lit("r034", 4'hC, 4'hC, 2'b10, 13'b0, 1'b1);
        lit("r035", 4'h3, 4'h6, 2'b00, 13'b0, 1'b0);
        lit("open_low", 4'h7, 4'h5, 2'b11, 13'b0, 1'b1);
        lit("high_wrong", 4'hF, 4'h1, 2'b01, 13'b11_0001_1111_01_1, 1'b0);
        lit("repeat_viol", 4'hF, 4'h1, 2'b01, 13'b11_0001_1111_01_1, 1'b0);

        // Held violation drives the counter into saturation.
        drive(1'b0, 4'h9, 4'h3, 2'b10);
        repeat (300) @(posedge clk);
        #1;
        check("hold_monitor", int'(monitor), int'(13'b11_0011_1001_10_1));
`ifdef MWM_VIOL_COUNT_EN
        check("saturate_count", int'(viol_count), 255);
`endif

        // Reset raised while the violation is still presented.
        drive(1'b1, 4'h9, 4'h3, 2'b10);
        @(posedge clk); #1;
        check("midrst_monitor", int'(monitor), 0);
        check("midrst_ok", int'(write_ok), 0);
`ifdef MWM_VIOL_COUNT_EN
        check("midrst_count", int'(viol_count), 0);
`endif
        lit("post_rst_first", 4'hB, 4'h2, 2'b11, 13'b11_0010_1011_11_1, 1'b0);

        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)));
        end
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule

// File: doc/memory_write_monitor.md
MEMORY_WRITE_MONITOR -- requirements
Module: memory_write_monitor

Interface
REQ-001 Parameter ADDR_W, default 4, write address width; only value 4 is required.
REQ-002 Parameter DATA_W, default 4, write data width; only value 4 is required.
REQ-003 Parameter ID_W, default 2, requester module ID width; only value 2 is required.
REQ-004 Parameter VIOL_CODE, default 2'b11, status code reported on an unauthorized write.
REQ-005 wb_clk_i  input  1  single clock; all logic is on the rising edge.
REQ-006 wb_rst_i  input  1  reset, synchronous and active-high.
REQ-007 write_addr_i  input  4  address of the observed write.
REQ-008 write_data_i  input  4  data of the observed write.
REQ-009 write_id_i  input  2  ID of the module issuing the write.
REQ-010 monitor_o  output  13  violation report {status[12:11], data[10:7], addr[6:3], id[2:1], alert[0]}.
REQ-011 write_ok_o  output  1  high when the current write is authorized.
REQ-012 viol_count_o  output  8  saturating violation count; present only with MWM_VIOL_COUNT_EN.

Function
REQ-013 Inputs SHALL be evaluated every cycle as a level-valid write; there is no strobe.
REQ-014 Access policy, addresses 0x0-0x7: open to any nonzero ID.
REQ-015 Access policy, addresses 0x8-0xB: authorized only for ID 2'b01.
REQ-016 Access policy, addresses 0xC-0xF: authorized only for ID 2'b10.
REQ-017 ID 2'b00 SHALL mean "no requester": the write is neither authorized nor a violation.
REQ-018 Authorized write -> next cycle: monitor_o = 13'b0, write_ok_o = 1.
REQ-019 Unauthorized write -> next cycle: monitor_o = {VIOL_CODE, data, addr, id, 1'b1}, write_ok_o = 0.
REQ-020 Idle cycle (ID 00) -> next cycle: monitor_o = 0, write_ok_o = 0.
REQ-021 Latency SHALL be exactly one clock, with registered outputs.
REQ-022 monitor_o SHALL NOT be sticky; it SHALL follow the most recently sampled write.
REQ-023 Consecutive violations SHALL each produce a fresh report, including the same report repeated.
REQ-024 Any X/Z on an input SHALL be treated as idle (no alert, write_ok_o = 0).

Reset
REQ-025 While wb_rst_i = 1 at a rising edge: monitor_o = 0, write_ok_o = 0, viol_count_o = 0.
REQ-026 Reset SHALL take priority over a simultaneous violation; that violation is not counted.
REQ-027 The first evaluation after reset SHALL use the inputs sampled on the first non-reset edge.

Configuration
REQ-028 Macro MWM_VIOL_COUNT_EN is the single compile-time option.
REQ-029 With MWM_VIOL_COUNT_EN defined: viol_count_o increments by 1 on each cycle a violation is registered, saturating at 8'hFF.
REQ-030 With MWM_VIOL_COUNT_EN undefined: the viol_count_o port and counter logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-031 addr 0x9, data 0xF, ID 10 -> monitor_o = 13'b11_1111_1001_10_1, write_ok_o = 0.
REQ-032 addr 0xA, data 0xA, ID 01 -> monitor_o = 13'b0, write_ok_o = 1.
REQ-033 addr 0xA, data 0xF, ID 11 -> monitor_o = 13'b11_1111_1010_11_1; with the macro, viol_count_o increments.
REQ-034 addr 0xC, data 0xC, ID 10 -> monitor_o = 0, write_ok_o = 1.
REQ-035 addr 0x3, any data, ID 00 -> monitor_o = 0, write_ok_o = 0.
REQ-036 Hold a violation for 300 cycles -> viol_count_o saturates at 8'hFF.
REQ-037 Assert wb_rst_i mid-violation -> all outputs 0 on the next edge.
